// File: rtl/pulse_stretcher_mc.sv
// pulse_stretcher_mc: multi-channel runtime-configurable pulse stretcher with hold-off and missed-trigger flags
//   clk            : single clock, rising edge
//   rst_n          : synchronous active-low reset
//   i_pulse_in     : per-channel trigger inputs
//   i_stretch_len  : output pulse length in cycles (0 disables triggering)
//   i_holdoff_len  : dead time after a pulse before re-arm (0 = none)
//   i_retrig_en    : trigger while stretching reloads the length
//   i_edge_mode    : 1 = rising-edge trigger, 0 = level trigger
//   i_clr_missed   : clears all sticky missed flags
//   o_pulse_out    : stretched pulses (registered)
//   o_busy         : channel not idle (registered)
//   o_missed       : sticky dropped-trigger flags (registered)
module pulse_stretcher_mc #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] i_pulse_in,
    input  logic [CNT_W-1:0]  i_stretch_len,
    input  logic [CNT_W-1:0]  i_holdoff_len,
    input  logic              i_retrig_en,
    input  logic              i_edge_mode,
    input  logic              i_clr_missed,
    output logic [NUM_CH-1:0] o_pulse_out,
    output logic [NUM_CH-1:0] o_busy,
    output logic [NUM_CH-1:0] o_missed
);
    typedef enum logic [1:0] {IDLE, STRETCH, HOLDOFF} state_t;
    logic [NUM_CH-1:0] r_pulse_in_d;
    logic [NUM_CH-1:0] w_trig;
    logic [CNT_W-1:0]  w_stretch_ld;
    logic [CNT_W-1:0]  w_holdoff_ld;
    assign w_trig = i_edge_mode ? (i_pulse_in & ~r_pulse_in_d) : i_pulse_in;
    // saturating load values so a zero length never wraps the counter
    assign w_stretch_ld = (i_stretch_len == '0) ? '0 : i_stretch_len - CNT_W'(1);
    assign w_holdoff_ld = (i_holdoff_len == '0) ? '0 : i_holdoff_len - CNT_W'(1);
    always_ff @(posedge clk) begin
        if (!rst_n) r_pulse_in_d <= '0;
        else r_pulse_in_d <= i_pulse_in;
    end
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nx;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nx;
        logic             w_miss_set;
        logic             r_pulse;
        logic             r_busy;
        logic             r_missed;
        always_comb begin
            w_state_nx = r_state;
            w_cnt_nx   = r_cnt;
            w_miss_set = 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_trig[g] && i_stretch_len != '0) begin
                        w_state_nx = STRETCH;
                        w_cnt_nx   = w_stretch_ld;
                    end
                end
                STRETCH: begin
                    // reload takes priority over expiry; a non-retrig trigger only flags and keeps counting
                    if (w_trig[g] && i_retrig_en) begin
                        w_cnt_nx = w_stretch_ld;
                    end else begin
                        w_miss_set = w_trig[g];
                        if (r_cnt == '0) begin
                            w_state_nx = (i_holdoff_len == '0) ? IDLE : HOLDOFF;
                            w_cnt_nx   = w_holdoff_ld;
                        end else begin
                            w_cnt_nx = r_cnt - CNT_W'(1);
                        end
                    end
                end
                HOLDOFF: begin
                    w_miss_set = w_trig[g];
                    if (r_cnt == '0) w_state_nx = IDLE;
                    else w_cnt_nx = r_cnt - CNT_W'(1);
                end
                default: w_state_nx = IDLE;
            endcase
        end
        // outputs registered from next state so they coincide with the state register
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state  <= IDLE;
                r_cnt    <= '0;
                r_pulse  <= 1'b0;
                r_busy   <= 1'b0;
                r_missed <= 1'b0;
            end else begin
                r_state  <= w_state_nx;
                r_cnt    <= w_cnt_nx;
                r_pulse  <= (w_state_nx == STRETCH);
                r_busy   <= (w_state_nx != IDLE);
                r_missed <= w_miss_set | (r_missed & ~i_clr_missed);
            end
        end
        assign o_pulse_out[g] = r_pulse;
        assign o_busy[g]      = r_busy;
        assign o_missed[g]    = r_missed;
    end
endmodule

// File: tb/tb_pulse_stretcher_mc.sv
// tb_pulse_stretcher_mc: scoreboard bench for pulse_stretcher_mc with cycle-stamped expectations
module tb_pulse_stretcher_mc;
    typedef struct {
        int         c;
        logic [3:0] p;
        logic [3:0] b;
        logic [3:0] m;
        string      nm;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pin;
    logic [7:0] sl;
    logic [7:0] hl;
    logic       re;
    logic       em;
    logic       clr;
    logic [3:0] po;
    logic [3:0] bz;
    logic [3:0] ms;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    exp_t       q[$];
    exp_t       mon_e;
    pulse_stretcher_mc #(.NUM_CH(4), .CNT_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_pulse_in(pin),
        .i_stretch_len(sl),
        .i_holdoff_len(hl),
        .i_retrig_en(re),
        .i_edge_mode(em),
        .i_clr_missed(clr),
        .o_pulse_out(po),
        .o_busy(bz),
        .o_missed(ms)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic void exp_at(int c, logic [3:0] p, logic [3:0] b, logic [3:0] m, string nm);
        exp_t e;
        int i;
        e.c = c;
        e.p = p;
        e.b = b;
        e.m = m;
        e.nm = nm;
        i = q.size();
        while (i > 0 && q[i-1].c > c) i--;
        q.insert(i, e);
    endfunction
    function automatic void exp_rng(int c0, int c1, logic [3:0] p, logic [3:0] b, logic [3:0] m, string nm);
        for (int c = c0; c <= c1; c++) exp_at(c, p, b, m, nm);
    endfunction
    task automatic tick(int k = 1);
        repeat (k) @(negedge clk);
    endtask
    always @(negedge clk) begin
        while (q.size() != 0 && q[0].c <= cyc) begin
            mon_e = q.pop_front();
            n_cmp++;
            if (mon_e.c != cyc) begin
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", mon_e.nm, mon_e.c, cyc);
            end else if ({po, bz, ms} !== {mon_e.p, mon_e.b, mon_e.m}) begin
                n_bad++;
                $display("FAIL %s @%0d: got pulse=%b busy=%b missed=%b, want pulse=%b busy=%b missed=%b",
                         mon_e.nm, cyc, po, bz, ms, mon_e.p, mon_e.b, mon_e.m);
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int n;
        int m;
        int w;
        logic hi;
        rst_n = 1'b0; pin = '0; sl = '0; hl = '0; re = 1'b0; em = 1'b1; clr = 1'b0;
        tick(2);
        exp_at(cyc + 1, 4'h0, 4'h0, 4'h0, "reset");
        tick;
        rst_n = 1'b1;
        // single edge trigger, L=5
        sl = 8'd5;
        n = cyc + 1;
        exp_rng(n, n + 4, 4'h1, 4'h1, 4'h0, "t1_hi");
        exp_rng(n + 5, n + 6, 4'h0, 4'h0, 4'h0, "t1_lo");
        pin = 4'h1; tick; pin = 4'h0; tick(7);
        // retrigger extends to 8 cycles
        re = 1'b1;
        n = cyc + 1;
        exp_rng(n, n + 7, 4'h2, 4'h2, 4'h0, "t2_retrig_hi");
        exp_at(n + 8, 4'h0, 4'h0, 4'h0, "t2_retrig_lo");
        pin = 4'h2; tick; pin = 4'h0; tick(2); pin = 4'h2; tick; pin = 4'h0; tick(6);
        // ignore-while-busy keeps 5 cycles and flags missed
        re = 1'b0;
        n = cyc + 1;
        exp_rng(n, n + 2, 4'h2, 4'h2, 4'h0, "t2_noretrig_hi");
        exp_rng(n + 3, n + 4, 4'h2, 4'h2, 4'h2, "t2_noretrig_miss");
        exp_rng(n + 5, n + 6, 4'h0, 4'h0, 4'h2, "t2_noretrig_lo");
        pin = 4'h2; tick; pin = 4'h0; tick(2); pin = 4'h2; tick; pin = 4'h0; tick(6);
        clr = 1'b1;
        exp_at(cyc + 1, 4'h0, 4'h0, 4'h0, "t2_clr");
        tick; clr = 1'b0; tick;
        // hold-off: L=3, H=4 on ch2
        sl = 8'd3; hl = 8'd4;
        n = cyc + 1;
        exp_rng(n, n + 2, 4'h4, 4'h4, 4'h0, "t3_hi");
        exp_rng(n + 3, n + 4, 4'h0, 4'h4, 4'h0, "t3_hold");
        exp_rng(n + 5, n + 6, 4'h0, 4'h4, 4'h4, "t3_hold_miss");
        exp_at(n + 7, 4'h0, 4'h0, 4'h4, "t3_idle");
        exp_rng(n + 8, n + 10, 4'h4, 4'h4, 4'h4, "t3_rearm_hi");
        exp_rng(n + 11, n + 14, 4'h0, 4'h4, 4'h4, "t3_hold2");
        exp_at(n + 15, 4'h0, 4'h0, 4'h4, "t3_idle2");
        exp_at(n + 16, 4'h0, 4'h0, 4'h0, "t3_clr");
        exp_rng(n + 17, n + 19, 4'h4, 4'h4, 4'h0, "t3_hi3");
        exp_rng(n + 20, n + 23, 4'h0, 4'h4, 4'h0, "t3_hold3");
        exp_rng(n + 24, n + 25, 4'h0, 4'h0, 4'h4, "t3_exit_miss");
        pin = 4'h4; tick; pin = 4'h0; tick(4);
        pin = 4'h4; tick; pin = 4'h0; tick(2);
        pin = 4'h4; tick; pin = 4'h0; tick(7);
        clr = 1'b1; tick; clr = 1'b0;
        pin = 4'h4; tick; pin = 4'h0; tick(6);
        pin = 4'h4; tick; pin = 4'h0; tick(2);
        clr = 1'b1; tick; clr = 1'b0; hl = 8'd0; tick;
        // level mode held high, L=2, H=0, clr coincident with a new miss
        em = 1'b0; sl = 8'd2;
        n = cyc + 1;
        for (int i = 0; i <= 12; i++) begin
            hi = (i inside {0, 1, 3, 4, 6, 7, 9, 10});
            exp_at(n + i, hi ? 4'h8 : 4'h0, hi ? 4'h8 : 4'h0, (i >= 1) ? 4'h8 : 4'h0, "t4_level");
        end
        pin = 4'h8; tick(4); clr = 1'b1; tick; clr = 1'b0; tick(5); pin = 4'h0; tick(3);
        clr = 1'b1;
        exp_at(cyc + 1, 4'h0, 4'h0, 4'h0, "t4_clr");
        tick; clr = 1'b0; em = 1'b1; tick;
        // all channels at once
        sl = 8'd3;
        n = cyc + 1;
        exp_rng(n, n + 2, 4'hF, 4'hF, 4'h0, "t5_all_hi");
        exp_at(n + 3, 4'h0, 4'h0, 4'h0, "t5_all_lo");
        pin = 4'hF; tick; pin = 4'h0; tick(4);
        // disabled channel
        sl = 8'd0;
        n = cyc + 1;
        exp_rng(n, n + 2, 4'h0, 4'h0, 4'h0, "t5_zero_len");
        pin = 4'h1; tick; pin = 4'h0; tick(3);
        // maximum length
        sl = 8'd255;
        n = cyc + 1;
        exp_rng(n, n + 254, 4'h1, 4'h1, 4'h0, "t5_max_hi");
        exp_rng(n + 255, n + 256, 4'h0, 4'h0, 4'h0, "t5_max_lo");
        pin = 4'h1; tick; pin = 4'h0; tick(257);
        // reset mid-pulse then a fresh full pulse
        sl = 8'd100;
        n = cyc + 1;
        exp_rng(n, n + 39, 4'h1, 4'h1, 4'h0, "t6_pre_rst");
        exp_rng(n + 40, n + 41, 4'h0, 4'h0, 4'h0, "t6_rst");
        pin = 4'h1; tick; pin = 4'h0; tick(39);
        rst_n = 1'b0; tick; rst_n = 1'b1; tick;
        m = cyc + 1;
        exp_rng(m, m + 99, 4'h1, 4'h1, 4'h0, "t6_fresh_hi");
        exp_at(m + 100, 4'h0, 4'h0, 4'h0, "t6_fresh_lo");
        pin = 4'h1; tick; pin = 4'h0; tick(101);
        w = 0;
        while (q.size() != 0 && w < 20) begin
            tick;
            w++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
